// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between the AHB-lite register block and the USB TX/RX packet engines.
// One write port fed by either producer and one read port drained by either consumer; the head byte is show-ahead.
module usb_data_buffer #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       get_rx_data,
  output logic [7:0] rx_data,
  input  logic       store_rx_packet_data,
  input  logic [7:0] rx_packet_data,
  input  logic       get_tx_packet_data,
  output logic [7:0] tx_packet_data,
  output logic [6:0] buffer_occupancy,
  output logic       buffer_error
);

  localparam logic [6:0] FULL_COUNT = 7'(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] wptr;
  logic [ADDR_BITS-1:0] rptr;
  logic [6:0]           occ;
  logic [6:0]           occ_next;

  logic       wr_req;
  logic       rd_req;
  logic       wr_ok;
  logic       rd_ok;
  logic       drop;
  logic       mem_we;
  logic [7:0] wr_byte;
  logic [7:0] head_byte;

  // Request arbitration and accept rules, all judged against the registered occupancy.
  // NOTE: every signal gets a default at the top of always_comb so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    wr_ok     = 1'b0;
    rd_ok     = 1'b0;
    drop      = 1'b0;
    mem_we    = 1'b0;
    wr_byte   = 8'h00;
    head_byte = 8'h00;
    occ_next  = occ;

    wr_req  = store_tx_data | store_rx_packet_data;
    rd_req  = get_rx_data | get_tx_packet_data;
    // The AHB write strobe has priority; a simultaneous USB RX byte is silently lost.
    wr_byte = store_tx_data ? tx_data : rx_packet_data;

    rd_ok = rd_req & (occ != 7'd0);
    // A write at full only fits when a pop frees the slot in the same cycle; an empty read never bypasses.
    wr_ok = wr_req & ((occ != FULL_COUNT) | rd_ok);
    drop  = (wr_req & ~wr_ok) | (rd_req & ~rd_ok);

    mem_we = wr_ok & ~clear & n_rst;

    unique case ({wr_ok, rd_ok})
      2'b10:   occ_next = occ + 7'd1;
      2'b01:   occ_next = occ - 7'd1;
      default: occ_next = occ;
    endcase

    if (occ != 7'd0) begin
      head_byte = mem[rptr];
    end
  end

  assign rx_data          = head_byte;
  assign tx_packet_data   = head_byte;
  assign buffer_occupancy = occ;

  // NOTE: the storage array has no reset; its contents are only observable through rptr/occ, which are reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr] <= wr_byte;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two and they are exactly ADDR_BITS wide.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr         <= '0;
      rptr         <= '0;
      occ          <= 7'd0;
      buffer_error <= 1'b0;
    end else if (clear) begin
      wptr         <= '0;
      rptr         <= '0;
      occ          <= 7'd0;
      buffer_error <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + ADDR_BITS'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + ADDR_BITS'(1);
      end
      occ          <= occ_next;
      buffer_error <= drop;
    end
  end

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: directed scenarios plus a randomized run,
// all compared against a queue-based model of the FIFO's accept/drop rules.
module tb_usb_data_buffer;

  localparam int DEPTH = 64;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_rx_data;
  logic [7:0] rx_data;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buffer_error;

  usb_data_buffer #(.DEPTH(DEPTH), .ADDR_BITS(6)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_error         (buffer_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the FIFO contents as a plain queue plus the expected error pulse.
  logic [7:0] q[$];
  logic       exp_err;

  function automatic logic [7:0] exp_head();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  function automatic logic [6:0] exp_occ();
    return 7'(q.size());
  endfunction

  // Apply one cycle of strobes, advance the model by the same cycle, sample #1 after the edge.
  task automatic drive(input logic s_tx, input logic [7:0] d_tx, input logic s_rx, input logic [7:0] d_rx,
                       input logic g_rx, input logic g_tx, input logic clr);
    logic wr_req, rd_req, rd_ok, wr_ok;
    logic [7:0] popped;
    store_tx_data        = s_tx;
    tx_data              = d_tx;
    store_rx_packet_data = s_rx;
    rx_packet_data       = d_rx;
    get_rx_data          = g_rx;
    get_tx_packet_data   = g_tx;
    clear                = clr;
    wr_req = s_tx | s_rx;
    rd_req = g_rx | g_tx;
    rd_ok  = rd_req && (q.size() != 0);
    wr_ok  = wr_req && ((q.size() < DEPTH) || rd_ok);
    @(posedge clk);
    if (clr) begin
      q.delete();
      exp_err = 1'b0;
    end else begin
      if (rd_ok) popped = q.pop_front();
      if (wr_ok) q.push_back(s_tx ? d_tx : d_rx);
      exp_err = (wr_req && !wr_ok) || (rd_req && !rd_ok);
    end
    #1;
    store_tx_data        = 1'b0;
    store_rx_packet_data = 1'b0;
    get_rx_data          = 1'b0;
    get_tx_packet_data   = 1'b0;
    clear                = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    q.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL reset_occ: got %0d want 0", buffer_occupancy); else n_pass++;
    n_checks++; if (buffer_error !== 1'b0) $display("FAIL reset_err: got %b want 0", buffer_error); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
    n_checks++; if (tx_packet_data !== 8'h00) $display("FAIL reset_tx_pkt: got %h want 00", tx_packet_data); else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_tx_basic();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA1 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (buffer_occupancy !== 7'd4) $display("FAIL tx_basic_occ: got %0d want 4", buffer_occupancy); else n_pass++;
    n_checks++; if (tx_packet_data !== 8'hA1) $display("FAIL tx_basic_head: got %h want a1", tx_packet_data); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_packet_data !== 8'hA1 + 8'(i)) $display("FAIL tx_basic_read%0d: got %h want %h", i, tx_packet_data, 8'hA1 + 8'(i));
      else n_pass++;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++; if (buffer_error !== 1'b0) $display("FAIL tx_basic_err%0d: got %b want 0", i, buffer_error); else n_pass++;
    end
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL tx_basic_empty_occ: got %0d want 0", buffer_occupancy); else n_pass++;
    n_checks++; if (tx_packet_data !== 8'h00) $display("FAIL tx_basic_empty_out: got %h want 00", tx_packet_data); else n_pass++;
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 64; i++) drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    n_checks++; if (buffer_occupancy !== 7'd64) $display("FAIL full_occ: got %0d want 64", buffer_occupancy); else n_pass++;
    n_checks++; if (buffer_error !== 1'b0) $display("FAIL full_no_err: got %b want 0", buffer_error); else n_pass++;
    drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    n_checks++; if (buffer_error !== 1'b1) $display("FAIL overflow_err: got %b want 1", buffer_error); else n_pass++;
    n_checks++; if (buffer_occupancy !== 7'd64) $display("FAIL overflow_occ: got %0d want 64", buffer_occupancy); else n_pass++;
    idle();
    n_checks++; if (buffer_error !== 1'b0) $display("FAIL overflow_pulse_len: got %b want 0", buffer_error); else n_pass++;
    for (int i = 0; i < 64; i++) begin
      n_checks++; if (rx_data !== 8'(i)) $display("FAIL full_drain%0d: got %h want %h", i, rx_data, 8'(i)); else n_pass++;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL full_drained_occ: got %0d want 0", buffer_occupancy); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL full_drained_out: got %h want 00", rx_data); else n_pass++;
  endtask

  task automatic test_full_rw();
    logic [7:0] got;
    for (int i = 0; i < 64; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++; if (buffer_occupancy !== 7'd64) $display("FAIL full_rw_occ: got %0d want 64", buffer_occupancy); else n_pass++;
    n_checks++; if (buffer_error !== 1'b0) $display("FAIL full_rw_err: got %b want 0", buffer_error); else n_pass++;
    n_checks++; if (rx_data !== exp_head()) $display("FAIL full_rw_advance: got %h want %h", rx_data, exp_head()); else n_pass++;
    got = 8'h00;
    for (int i = 0; i < 64; i++) begin
      n_checks++; if (rx_data !== exp_head()) $display("FAIL full_rw_drain%0d: got %h want %h", i, rx_data, exp_head()); else n_pass++;
      got = rx_data;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_checks++; if (got !== 8'h55) $display("FAIL full_rw_last: got %h want 55", got); else n_pass++;
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL full_rw_empty: got %0d want 0", buffer_occupancy); else n_pass++;
  endtask

  task automatic test_empty_rw();
    drive(1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    n_checks++; if (buffer_error !== 1'b1) $display("FAIL empty_rw_err: got %b want 1", buffer_error); else n_pass++;
    n_checks++; if (buffer_occupancy !== 7'd1) $display("FAIL empty_rw_occ: got %0d want 1", buffer_occupancy); else n_pass++;
    n_checks++; if (rx_data !== 8'h3C) $display("FAIL empty_rw_data: got %h want 3c", rx_data); else n_pass++;
    // Both read strobes together must pop exactly one byte.
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL dual_read_occ: got %0d want 0", buffer_occupancy); else n_pass++;
    n_checks++; if (buffer_error !== 1'b0) $display("FAIL dual_read_err: got %b want 0", buffer_error); else n_pass++;
    // Both write strobes together: only the AHB byte is stored, no error.
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    n_checks++; if (buffer_occupancy !== 7'd1) $display("FAIL dual_write_occ: got %0d want 1", buffer_occupancy); else n_pass++;
    n_checks++; if (tx_packet_data !== 8'h11) $display("FAIL dual_write_data: got %h want 11", tx_packet_data); else n_pass++;
    n_checks++; if (buffer_error !== 1'b0) $display("FAIL dual_write_err: got %b want 0", buffer_error); else n_pass++;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++; if (buffer_occupancy !== 7'd40) $display("FAIL wrap_fill_occ: got %0d want 40", buffer_occupancy); else n_pass++;
    for (int i = 0; i < 40; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      n_checks++; if (buffer_occupancy !== 7'(i + 1)) $display("FAIL wrap_occ_up%0d: got %0d want %0d", i, buffer_occupancy, i + 1); else n_pass++;
    end
    for (int i = 0; i < 40; i++) begin
      n_checks++; if (tx_packet_data !== exp_head()) $display("FAIL wrap_read%0d: got %h want %h", i, tx_packet_data, exp_head()); else n_pass++;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++; if (buffer_occupancy !== 7'(39 - i)) $display("FAIL wrap_occ_dn%0d: got %0d want %0d", i, buffer_occupancy, 39 - i); else n_pass++;
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i + 100), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL clear_occ: got %0d want 0", buffer_occupancy); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL clear_out: got %h want 00", rx_data); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h99, 1'b1, 8'h98, 1'b1, 1'b1, 1'b1);
      n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL clear_hold_occ%0d: got %0d want 0", i, buffer_occupancy); else n_pass++;
      n_checks++; if (buffer_error !== 1'b0) $display("FAIL clear_hold_err%0d: got %b want 0", i, buffer_error); else n_pass++;
    end
    drive(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    n_checks++; if (rx_data !== 8'h77) $display("FAIL clear_rewrite: got %h want 77", rx_data); else n_pass++;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL clear_reread_occ: got %0d want 0", buffer_occupancy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom_range(1, 255)), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    store_tx_data = 1'b1;
    tx_data       = 8'h5A;
    #2;
    n_rst = 1'b0;
    #1;
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL async_rst_occ: got %0d want 0", buffer_occupancy); else n_pass++;
    n_checks++; if (tx_packet_data !== 8'h00) $display("FAIL async_rst_out: got %h want 00", tx_packet_data); else n_pass++;
    q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    store_tx_data = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    idle();
    n_checks++; if (buffer_occupancy !== 7'd0) $display("FAIL post_rst_occ: got %0d want 0", buffer_occupancy); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL post_rst_out: got %h want 00", rx_data); else n_pass++;
  endtask

  task automatic test_random();
    int p_wr, p_rd;
    for (int c = 0; c < 3000; c++) begin
      p_wr = ((c / 250) % 2 == 0) ? 70 : 30;
      p_rd = 100 - p_wr;
      drive($urandom_range(0, 99) < p_wr / 2, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < p_wr / 2, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < p_rd / 2, $urandom_range(0, 99) < p_rd / 2,
            $urandom_range(0, 299) == 0);
      n_checks++; if (buffer_occupancy !== exp_occ()) $display("FAIL rand_occ@%0d: got %0d want %0d", c, buffer_occupancy, exp_occ()); else n_pass++;
      n_checks++; if (buffer_error !== exp_err) $display("FAIL rand_err@%0d: got %b want %b", c, buffer_error, exp_err); else n_pass++;
      n_checks++; if (rx_data !== exp_head()) $display("FAIL rand_rx@%0d: got %h want %h", c, rx_data, exp_head()); else n_pass++;
      n_checks++; if (tx_packet_data !== exp_head()) $display("FAIL rand_tx@%0d: got %h want %h", c, tx_packet_data, exp_head()); else n_pass++;
    end
  endtask

  initial begin
    n_rst                = 1'b0;
    clear                = 1'b0;
    store_tx_data        = 1'b0;
    tx_data              = 8'h00;
    get_rx_data          = 1'b0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'h00;
    get_tx_packet_data   = 1'b0;
    exp_err              = 1'b0;
    test_reset();
    test_tx_basic();
    test_full_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
